// File: rtl/alu_regfile_pkg.sv
// alu_regfile_pkg
// Shared definitions for the parametrised ALU / register-file core:
//   - opcode encodings (4-bit op field)
//   - bit positions inside the 4-bit flags word {Z,N,V,C}
//   - multiplier sequencer state encoding
//   - addr_w(): register-file index width, never narrower than one bit
package alu_regfile_pkg;

  localparam logic [3:0] OP_ADD       = 4'd0;
  localparam logic [3:0] OP_SUB       = 4'd1;
  localparam logic [3:0] OP_AND       = 4'd2;
  localparam logic [3:0] OP_OR        = 4'd3;
  localparam logic [3:0] OP_XOR       = 4'd4;
  localparam logic [3:0] OP_SHL       = 4'd5;
  localparam logic [3:0] OP_PASS_A    = 4'd6;
  localparam logic [3:0] OP_PASS_B    = 4'd7;
  localparam logic [3:0] OP_REG_WRITE = 4'd8;
  localparam logic [3:0] OP_REG_READ  = 4'd9;
  localparam logic [3:0] OP_ADD_REG   = 4'd10;
  localparam logic [3:0] OP_SUB_REG   = 4'd11;
  localparam logic [3:0] OP_MUL       = 4'd12;
  localparam logic [3:0] OP_ADDC      = 4'd13;
  localparam logic [3:0] OP_CMP       = 4'd14;
  localparam logic [3:0] OP_NOP       = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  function automatic int addr_w(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Iterative shift-add multiplier. One partial product per clock; the first
// one is folded into the start edge so the full product is ready in the
// last busy cycle and the caller can capture it DATA_W edges after start.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (aborts a multiply)
//   start     : begin a multiply of a*b (only honoured while idle)
//   a, b      : operands, sampled on the start edge
//   busy      : high while a multiply is in flight (this is the FSM state:
//               busy == (state == MUL_RUN))
//   done      : high in the final busy cycle; product is valid then
//   product   : full 2*DATA_W-bit product (accumulator)
module alu_mul_seq
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

  mul_state_e state_q, state_d;

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;

  // cnt_q counts partial products already accumulated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_RUN;
      MUL_RUN:  if (cnt_q == LAST_STEP) state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MUL_IDLE && start) begin
        // Partial product for b[0] is taken on the start edge.
        acc_q    <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
        mcand_q  <= {{DATA_W{1'b0}}, a} << 1;
        mplier_q <= b >> 1;
        cnt_q    <= CNT_W'(1);
      end else if (state_q == MUL_RUN && cnt_q != LAST_STEP) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy    = (state_q == MUL_RUN);
  assign done    = busy && (cnt_q == LAST_STEP);
  assign product = acc_q;

endmodule

// File: rtl/alu_regfile_param.sv
// alu_regfile_param
// Arithmetic core with a small register file. Single-cycle ops update the
// registered result/flags on the accepting edge; MUL runs on the sequential
// multiplier and lands DATA_W edges after acceptance.
// Handshake: an op is taken on a rising edge where in_valid && in_ready.
//   in_ready = ~busy & ~rst. A source that sees in_ready low holds in_valid
//   and its operands stable until the accepting edge. out_valid is a
//   one-cycle pulse marking each completed op; result/flags hold between.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : request handshake
//   op, a, b, addr     : opcode, operands, register index
//   out_valid          : completion pulse
//   result, flags      : registered result and {Z,N,V,C}
module alu_regfile_param
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int ADDR_W = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] regs [NREG];

  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic                accept;
  logic                addr_ok;
  logic [DATA_W-1:0]   rd_data;

  logic [DATA_W-1:0]   opnd_b;
  logic                cin;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;
  logic                v_add;
  logic                v_sub;
  logic [DATA_W-1:0]   calc;
  logic                calc_c;
  logic                calc_v;
  logic                upd_result;
  logic                upd_flags;
  logic [3:0]          new_flags;

  logic [DATA_W-1:0]   mul_lo;
  logic                mul_hi_nz;

  assign in_ready = ~mul_busy & ~rst;
  assign accept   = in_valid & in_ready;

  // Out-of-range indices read as zero and never write.
  assign addr_ok = (int'(addr) < NREG);
  assign rd_data = addr_ok ? regs[addr] : '0;

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (op == OP_MUL)),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_lo    = mul_product[DATA_W-1:0];
  assign mul_hi_nz = |mul_product[2*DATA_W-1:DATA_W];

  always_comb begin
    opnd_b     = (op == OP_ADD_REG || op == OP_SUB_REG) ? rd_data : b;
    cin        = (op == OP_ADDC) ? flags[FLAG_C] : 1'b0;
    sum_w      = {1'b0, a} + {1'b0, opnd_b} + {{DATA_W{1'b0}}, cin};
    diff_w     = {1'b0, a} - {1'b0, opnd_b};
    v_add      = (a[MSB] == opnd_b[MSB]) && (sum_w[MSB] != a[MSB]);
    v_sub      = (a[MSB] != opnd_b[MSB]) && (diff_w[MSB] != a[MSB]);
    calc       = result;
    calc_c     = 1'b0;
    calc_v     = 1'b0;
    upd_result = 1'b1;
    upd_flags  = 1'b1;
    case (op)
      OP_ADD, OP_ADDC, OP_ADD_REG: begin
        calc   = sum_w[DATA_W-1:0];
        calc_c = sum_w[DATA_W];
        calc_v = v_add;
      end
      OP_SUB, OP_SUB_REG, OP_CMP: begin
        // diff_w[DATA_W] is the borrow: set exactly when a < operand.
        calc       = diff_w[DATA_W-1:0];
        calc_c     = diff_w[DATA_W];
        calc_v     = v_sub;
        upd_result = (op != OP_CMP);
      end
      OP_AND:    calc = a & b;
      OP_OR:     calc = a | b;
      OP_XOR:    calc = a ^ b;
      OP_SHL: begin
        calc   = a << 1;
        calc_c = a[MSB];
      end
      OP_PASS_A:   calc = a;
      OP_PASS_B:   calc = b;
      OP_REG_READ: calc = rd_data;
      OP_REG_WRITE: begin
        calc      = a;
        upd_flags = 1'b0;
      end
      default: begin
        // MUL completes later via mul_done; NOP touches nothing.
        upd_result = 1'b0;
        upd_flags  = 1'b0;
      end
    endcase
    new_flags         = 4'b0000;
    new_flags[FLAG_Z] = (calc == '0);
    new_flags[FLAG_N] = calc[MSB];
    new_flags[FLAG_V] = calc_v;
    new_flags[FLAG_C] = calc_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      regs      <= '{default: '0};
    end else begin
      out_valid <= 1'b0;
      if (mul_done) begin
        result         <= mul_lo;
        flags[FLAG_Z]  <= (mul_lo == '0);
        flags[FLAG_N]  <= mul_lo[MSB];
        flags[FLAG_V]  <= mul_hi_nz;
        flags[FLAG_C]  <= mul_hi_nz;
        out_valid      <= 1'b1;
      end else if (accept && op != OP_MUL) begin
        out_valid <= 1'b1;
        if (upd_result) result <= calc;
        if (upd_flags)  flags  <= new_flags;
        if (op == OP_REG_WRITE && addr_ok) regs[addr] <= a;
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_param.sv
// tb_alu_regfile_param
// Directed plus random checks of alu_regfile_param (DATA_W=8, NREG=8).
// Expected {flags,result} words are produced by a behavioural model at the
// moment an op is accepted and queued; every out_valid pops one entry.
module tb_alu_regfile_param;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SHL = 4'd5,  OP_PASS_A = 4'd6, OP_PASS_B = 4'd7;
  localparam logic [3:0] OP_REG_WRITE = 4'd8, OP_REG_READ = 4'd9, OP_ADD_REG = 4'd10;
  localparam logic [3:0] OP_SUB_REG = 4'd11, OP_MUL = 4'd12, OP_ADDC = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14, OP_NOP = 4'd15;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] addr = '0;
  logic       out_valid;
  logic [7:0] result;
  logic [3:0] flags;

  always #5 clk = ~clk;

  alu_regfile_param #(.DATA_W(8), .NREG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .addr      (addr),
    .out_valid (out_valid),
    .result    (result),
    .flags     (flags)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_word;
  logic [7:0]  m_regs [8];
  logic [7:0]  m_res;
  logic [3:0]  m_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_res   = 8'h00;
    m_flags = 4'h0;
  endtask

  function automatic int to_signed8(input int u);
    return (u > 127) ? u - 256 : u;
  endfunction

  // Reference behaviour; flags word is {Z,N,V,C}.
  task automatic model_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [2:0] ad);
    int   ux, uy, sx, sy, r, sr, ci;
    logic c, v;
    logic [7:0] r8;
    bit   keep_res, keep_flags;
    ux = int'(x);
    uy = (o == OP_ADD_REG || o == OP_SUB_REG) ? int'(m_regs[ad]) : int'(y);
    sx = to_signed8(ux);
    sy = to_signed8(uy);
    ci = (o == OP_ADDC) ? int'(m_flags[0]) : 0;
    r = int'(m_res);
    c = 1'b0; v = 1'b0; keep_res = 0; keep_flags = 0;
    case (o)
      OP_ADD, OP_ADD_REG, OP_ADDC: begin
        r = ux + uy + ci; sr = sx + sy + ci;
        c = (r > 255); v = (sr > 127) || (sr < -128);
      end
      OP_SUB, OP_SUB_REG, OP_CMP: begin
        r = ux - uy; sr = sx - sy;
        c = (ux < uy); v = (sr > 127) || (sr < -128);
        keep_res = (o == OP_CMP);
      end
      OP_AND:       r = ux & uy;
      OP_OR:        r = ux | uy;
      OP_XOR:       r = ux ^ uy;
      OP_SHL: begin r = ux * 2; c = x[7]; end
      OP_PASS_A:    r = ux;
      OP_PASS_B:    r = uy;
      OP_REG_WRITE: begin r = ux; keep_flags = 1; m_regs[ad] = x; end
      OP_REG_READ:  r = int'(m_regs[ad]);
      OP_MUL: begin r = ux * uy; c = ((r >> 8) != 0); v = c; end
      default: begin keep_res = 1; keep_flags = 1; end
    endcase
    r8 = 8'(r & 255);
    if (!keep_flags) m_flags = {(r8 == 8'h00), r8[7], v, c};
    if (!keep_res)   m_res = r8;
    exp_q.push_back({m_flags, m_res});
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_word = exp_q.pop_front();
        check("sb_result", result, exp_word[7:0]);
        check("sb_flags", flags, exp_word[11:8]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [2:0] ad);
    int waits = 0;
    op = o; a = x; b = y; addr = ad; in_valid = 1'b1;
    while (!in_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    model_op(o, x, y, ad);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  int low_cnt;
  int ov_at;

  initial begin
    model_reset();

    // 1. reset held three edges
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 8'h00);
      check("rst_flags", flags, 4'h0);
    end
    rst = 1'b0;
    #1 check("ready_after_rst", in_ready, 1);
    @(negedge clk);

    // 2. register file
    drive_op(OP_REG_WRITE, 8'h07, 8'h00, 3'd3);
    drive_op(OP_REG_READ,  8'h00, 8'h00, 3'd3);
    check("reg_read_val", result, 8'h07);
    check("reg_read_z", flags[3], 0);
    drive_op(OP_ADD_REG, 8'h02, 8'h00, 3'd3);
    check("add_reg_val", result, 8'h09);
    drive_op(OP_SUB_REG, 8'h02, 8'h00, 3'd3);
    check("sub_reg_val", result, 8'hFB);
    check("sub_reg_flags", flags, 4'b0101);

    // 3. add overflow / carry / add-with-carry
    drive_op(OP_ADD, 8'h7F, 8'h01, 3'd0);
    check("add_ovf_val", result, 8'h80);
    check("add_ovf_flags", flags, 4'b0110);
    drive_op(OP_ADD, 8'hFF, 8'h01, 3'd0);
    check("add_carry_val", result, 8'h00);
    check("add_carry_flags", flags, 4'b1001);
    drive_op(OP_ADDC, 8'h00, 8'h00, 3'd0);
    check("addc_val", result, 8'h01);

    // 4. multiply latency, held request accepted in the out_valid cycle
    drive_op(OP_MUL, 8'h10, 8'h20, 3'd0);
    op = OP_ADD; a = 8'h01; b = 8'h02; addr = 3'd0; in_valid = 1'b1;
    low_cnt = 0; ov_at = -1;
    for (int i = 1; i <= 12 && ov_at < 0; i++) begin
      if (!in_ready) low_cnt++;
      @(negedge clk);
      if (out_valid) ov_at = i;
    end
    check("mul_latency", ov_at, 8);
    check("mul_ready_low", low_cnt, 8);
    check("mul_val", result, 8'h00);
    check("mul_flags", flags, 4'b1011);
    check("ready_in_ov_cycle", in_ready, 1);
    drive_op(OP_ADD, 8'h01, 8'h02, 3'd0);
    check("held_add_val", result, 8'h03);

    // 5. reset in the middle of a multiply
    drive_op(OP_MUL, 8'h03, 8'h05, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("abort_result", result, 8'h00);
    check("abort_flags", flags, 4'h0);
    rst = 1'b0;
    #1 check("ready_after_abort", in_ready, 1);
    repeat (8) @(negedge clk);
    drive_op(OP_REG_READ, 8'h00, 8'h00, 3'd3);
    check("regs_cleared", result, 8'h00);

    // 6. pass, compare, back-to-back write/read
    drive_op(OP_PASS_B, 8'h00, 8'h09, 3'd0);
    check("pass_b_val", result, 8'h09);
    drive_op(OP_CMP, 8'h05, 8'h05, 3'd0);
    check("cmp_keeps_result", result, 8'h09);
    check("cmp_flags", flags, 4'b1000);
    drive_op(OP_REG_WRITE, 8'hAA, 8'h00, 3'd7);
    drive_op(OP_REG_READ,  8'h00, 8'h00, 3'd7);
    check("b2b_read_val", result, 8'hAA);

    // random mix, all opcodes
    for (int n = 0; n < 40; n++) begin
      drive_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_regfile_param.md
Name: alu_regfile_param

Overview:
- Parametrised successor to the team's tiny 4-bit ALU: configurable data width and register-file depth, plus valid/ready input handshake and a registered result with an out_valid pulse.
- Adds an iterative multi-cycle multiply, add-with-carry and flags-only compare.
- Sits between the host/pin interface and downstream display/scope logic as the arithmetic core.

Parameters:
DATA_W, 8, operand/result width (>=4).
NREG, 8, register-file depth; ADDR_W = max(1, clog2(NREG)).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  core can accept; = ~busy & ~rst
op  in  4  opcode
a  in  DATA_W  operand A
b  in  DATA_W  operand B
addr  in  ADDR_W  register-file index
out_valid  out  1  one-cycle pulse: result/flags updated
result  out  DATA_W  registered result, held between pulses
flags  out  4  {Z,N,V,C}, registered, held

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst high at an edge) forces:
  - result=0, flags=0, out_valid=0, busy=0, all registers=0.
  - Any in-flight MUL is aborted, with no out_valid.
- Accept rule: an op is accepted at an edge where in_valid & in_ready. in_valid while busy is ignored; the source holds it.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: a<<1, C=a[MSB].
  - 6 PASS_A, 7 PASS_B.
  - 8 REG_WRITE: reg[addr]<=a, result=a, flags unchanged.
  - 9 REG_READ: result=reg[addr].
  - 10 ADD_REG: a+reg[addr].
  - 11 SUB_REG: a-reg[addr].
  - 12 MUL: low DATA_W bits of a*b.
  - 13 ADDC: a+b+flags.C.
  - 14 CMP: flags as SUB, result unchanged.
  - 15 NOP: out_valid pulses, nothing else changes.
- Arithmetic is modulo 2^DATA_W.
- Flags:
  - Z = result==0; N = result[MSB].
  - ADD/ADDC/ADD_REG: C=carry out, V=signed overflow.
  - SUB/SUB_REG/CMP: C=borrow (a<b unsigned), V=signed overflow.
  - Logic ops, PASS, REG_READ: C=V=0.
  - MUL: C=V=(high half of product !=0).
- Single-cycle ops: accepted at edge k; result/flags/out_valid visible after edge k; out_valid deasserts after edge k+1 unless another op is accepted.
- MUL state machine:
  - States: IDLE, RUN. Implemented as DATA_W-step shift-add.
  - Accept at edge k -> RUN, busy=1.
  - Result and out_valid land at edge k+DATA_W, which also returns the machine to IDLE.
  - in_ready is low for exactly DATA_W cycles; a new op may be accepted in the out_valid cycle.
- Register file:
  - Writes commit at the accepting edge; the next accepted op reads the new value (no stale read).
  - Reads sample at acceptance.
  - addr>=NREG: write dropped, read returns 0.
- The flags register is the ADDC carry source; REG_WRITE/NOP preserve it.

Decomposition:
- Package alu_regfile_pkg: opcode localparams, flag bit indices (Z=3, N=2, V=1, C=0), ADDR_W function.
- Sub-module alu_mul_seq (DATA_W):
  - Ports: start, a, b, busy, done, product[2*DATA_W-1:0].
  - Contains the iteration counter and the shift/accumulate registers.
  - Reset aborts it.

Test Plan (DATA_W=8, NREG=8):
1. Reset held 3 cycles then released -> result=0x00, flags=0000, out_valid=0 throughout reset, in_ready=1 on the first cycle after release.
2. REG_WRITE addr3 a=0x07, then REG_READ addr3 -> 0x07, Z=0. Then:
   - ADD_REG a=0x02 -> 0x09.
   - SUB_REG a=0x02 -> 0xFB with N=1, C=1, V=0.
3. ADD 0x7F+0x01 -> 0x80 with N=1, V=1, C=0. Then:
   - ADD 0xFF+0x01 -> 0x00 with Z=1, C=1.
   - ADDC 0x00+0x00 -> 0x01.
4. MUL 0x10*0x20 -> result 0x00, Z=1, C=V=1:
   - out_valid exactly 8 cycles after acceptance; in_ready low 8 cycles.
   - An ADD held on in_valid during busy is accepted on the out_valid cycle.
5. MUL 0x03*0x05, rst asserted 4 cycles in -> no out_valid; result=0, registers cleared; in_ready=1 the cycle after rst drops.
6. PASS_B b=0x09 -> 0x09. Then:
   - CMP 0x05,0x05 -> Z=1, C=0, result stays 0x09.
   - REG_WRITE addr=7 a=0xAA followed by REG_READ addr=7 on the next cycle -> 0xAA.
